// File: rtl/gate_response_checker.sv
// Receiving end of the gate stimulus driver: checks sampled {a,b,f} triples
// against a selected 2-input function and reports counts, coverage and verdict.
module gate_response_checker #(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       gate_sel,
    input  logic             smp_valid,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_f,
    output logic             smp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [3:0]       cov_map,
    output logic [2:0]       first_fail_vec,
    output logic [CNT_W-1:0] first_fail_idx
);
    localparam int IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic              COV_WAIVE = (NUM_SAMPLES < 4) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_timed_out;
    logic [1:0]         r_gate_sel;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_smp_cnt;
    logic [3:0]         r_cov_map;
    logic [2:0]         r_first_fail_vec;
    logic [CNT_W-1:0]   r_first_fail_idx;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic               w_accept;
    logic               w_expected;
    logic               w_match;
    logic               w_last;
    logic               w_timeout;

    function automatic logic gate_eval(input logic [1:0] sel, input logic a, input logic b);
        logic y;
        case (sel)
            2'd0:    y = a | b;
            2'd1:    y = a & b;
            2'd2:    y = a ^ b;
            2'd3:    y = ~(a & b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign smp_ready  = (r_state == ST_RUN) & ~start;
    assign w_accept   = smp_valid & smp_ready;
    assign w_expected = gate_eval(r_gate_sel, smp_a, smp_b);
    // An unknown observed output never compares equal, so it lands in the fail branch.
    assign w_match    = (smp_f == w_expected);
    assign w_last     = w_accept & (r_smp_cnt == LAST_IDX);
    assign w_timeout  = smp_ready & ~w_accept & (r_idle_cnt == IDLE_LAST);

    // Next-state selection; start wins from every state.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RUN:  w_state_nxt = (w_last | w_timeout) ? ST_DONE : ST_RUN;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with registered status flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Result datapath: counters, coverage, first-mismatch capture and idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate_sel       <= 2'd0;
            r_timed_out      <= 1'b0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_smp_cnt        <= '0;
            r_cov_map        <= 4'd0;
            r_first_fail_vec <= 3'd0;
            r_first_fail_idx <= '0;
            r_idle_cnt       <= '0;
        end else if (start) begin
            r_gate_sel       <= gate_sel;
            r_timed_out      <= 1'b0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_smp_cnt        <= '0;
            r_cov_map        <= 4'd0;
            r_first_fail_vec <= 3'd0;
            r_first_fail_idx <= '0;
            r_idle_cnt       <= '0;
        end else if (w_accept) begin
            if (w_match) begin
                r_pass_cnt <= sat_inc(r_pass_cnt);
            end else begin
                r_fail_cnt <= sat_inc(r_fail_cnt);
                // fail_cnt saturates rather than wraps, so zero means no mismatch yet.
                if (r_fail_cnt == '0) begin
                    r_first_fail_vec <= {smp_a, smp_b, smp_f};
                    r_first_fail_idx <= r_smp_cnt;
                end
            end
            r_smp_cnt                 <= sat_inc(r_smp_cnt);
            r_cov_map[{smp_a, smp_b}] <= 1'b1;
            r_idle_cnt                <= '0;
        end else if (r_state == ST_RUN) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign timed_out      = r_timed_out;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign smp_cnt        = r_smp_cnt;
    assign cov_map        = r_cov_map;
    assign first_fail_vec = r_first_fail_vec;
    assign first_fail_idx = r_first_fail_idx;
    assign pass           = r_done & (r_fail_cnt == '0) & ~r_timed_out &
                            ((r_cov_map == 4'hF) | COV_WAIVE);
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a behavioural run model checked every
// cycle, plus literal expectations taken from the hand-worked scenarios.
module tb_gate_response_checker;
    localparam int NS  = 4;
    localparam int CW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    gate_sel = 2'd0;
    logic          smp_valid = 1'b0, smp_a = 1'b0, smp_b = 1'b0, smp_f = 1'b0;
    logic          smp_ready, busy, done, pass, timed_out;
    logic [CW-1:0] pass_cnt, fail_cnt, smp_cnt, first_fail_idx;
    logic [3:0]    cov_map;
    logic [2:0]    first_fail_vec;

    int errors = 0;
    int checks = 0;

    gate_response_checker #(.NUM_SAMPLES(NS), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b), .smp_f(smp_f),
        .smp_ready(smp_ready), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .smp_cnt(smp_cnt), .cov_map(cov_map), .first_fail_vec(first_fail_vec),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: truth tables indexed by {a,b}, run phase 0=idle 1=run 2=done.
    logic [3:0] tt [4] = '{4'b1110, 4'b1000, 4'b0110, 4'b0111};
    int         m_mode, m_pc, m_fc, m_sc, m_idle, m_ffi;
    logic [1:0] m_sel;
    logic [3:0] m_cov;
    logic [2:0] m_ffv;
    logic       m_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pc = 0; m_fc = 0; m_sc = 0; m_idle = 0; m_ffi = 0;
            m_sel = 2'd0; m_cov = 4'd0; m_ffv = 3'd0; m_to = 1'b0;
        end else if (start) begin
            m_mode = 1; m_pc = 0; m_fc = 0; m_sc = 0; m_idle = 0; m_ffi = 0;
            m_sel = gate_sel; m_cov = 4'd0; m_ffv = 3'd0; m_to = 1'b0;
        end else if (m_mode == 1) begin
            if (smp_valid) begin
                if (smp_f === tt[m_sel][{smp_a, smp_b}]) m_pc++;
                else begin
                    if (m_fc == 0) begin
                        m_ffv = {smp_a, smp_b, smp_f};
                        m_ffi = m_sc;
                    end
                    m_fc++;
                end
                m_sc++;
                m_cov[{smp_a, smp_b}] = 1'b1;
                m_idle = 0;
                if (m_sc == NS) m_mode = 2;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_to = 1'b1;
                    m_mode = 2;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_ready", smp_ready, (m_mode == 1) && !start);
        chk("m_busy", busy, m_mode == 1);
        chk("m_done", done, m_mode == 2);
        chk("m_timed_out", timed_out, m_to);
        chk("m_pass_cnt", pass_cnt, m_pc);
        chk("m_fail_cnt", fail_cnt, m_fc);
        chk("m_smp_cnt", smp_cnt, m_sc);
        chk("m_cov_map", cov_map, m_cov);
        chk("m_ff_vec", first_fail_vec, m_ffv);
        chk("m_ff_idx", first_fail_idx, m_ffi);
        chk("m_pass", pass, (m_mode == 2) && m_fc == 0 && !m_to && (m_cov == 4'hF || NS < 4));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel);
        start = 1'b1;
        gate_sel = sel;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic a, input logic b, input logic f);
        smp_valid = 1'b1;
        smp_a = a; smp_b = b; smp_f = f;
        tick();
        smp_valid = 1'b0;
    endtask

    initial begin
        int n;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_smp_cnt", smp_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Samples offered in IDLE are refused.
        smp_valid = 1'b1; smp_a = 1'b1; smp_b = 1'b1; smp_f = 1'b1;
        tick(); tick();
        chk("idle_ready", smp_ready, 0);
        chk("idle_smp_cnt", smp_cnt, 0);
        smp_valid = 1'b0;

        // OR, four correct samples back-to-back.
        do_start(2'd0);
        chk("start_busy", busy, 1);
        send(0, 0, 0); send(0, 1, 1); send(1, 0, 1); send(1, 1, 1);
        chk("or_done", done, 1);
        chk("or_pass_cnt", pass_cnt, 4);
        chk("or_cov", cov_map, 4'hF);
        chk("or_pass", pass, 1);

        // Samples offered in DONE are refused and results hold.
        smp_valid = 1'b1; smp_a = 1'b0; smp_b = 1'b0; smp_f = 1'b1;
        #1 chk("done_ready", smp_ready, 0);
        tick(); tick();
        smp_valid = 1'b0;
        chk("done_hold_smp", smp_cnt, 4);
        chk("done_hold_fail", fail_cnt, 0);

        // OR with a single fault on the third sample.
        do_start(2'd0);
        send(0, 0, 0); send(0, 1, 1); send(1, 0, 0); send(1, 1, 1);
        chk("flt_fail_cnt", fail_cnt, 1);
        chk("flt_vec", first_fail_vec, 3'b100);
        chk("flt_idx", first_fail_idx, 2);
        chk("flt_pass", pass, 0);

        // NAND, four correct samples all {1,1,0}: coverage incomplete.
        do_start(2'd3);
        repeat (4) send(1, 1, 0);
        chk("nand_done", done, 1);
        chk("nand_cov", cov_map, 4'b1000);
        chk("nand_fail", fail_cnt, 0);
        chk("nand_pass", pass, 0);

        // Timeout: one XOR sample then silence; done lands 9 cycles after acceptance.
        do_start(2'd2);
        send(1, 0, 1);
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_flag", timed_out, 1);
        chk("tmo_smp_cnt", smp_cnt, 1);
        chk("tmo_pass", pass, 0);

        // Restart mid-run with a sample present: that sample is discarded.
        do_start(2'd1);
        send(1, 1, 1); send(0, 1, 0);
        start = 1'b1; smp_valid = 1'b1; smp_a = 1'b1; smp_b = 1'b1; smp_f = 1'b1;
        #1 chk("rs_ready", smp_ready, 0);
        tick();
        start = 1'b0; smp_valid = 1'b0;
        chk("rs_smp_cnt", smp_cnt, 0);
        chk("rs_pass_cnt", pass_cnt, 0);
        chk("rs_busy", busy, 1);
        send(1, 0, 0);
        chk("rs_after", pass_cnt, 1);

        // Asynchronous reset mid-run, checked before the next edge.
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_smp_cnt", smp_cnt, 0);
        chk("arst_cov", cov_map, 0);
        chk("arst_ready", smp_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        smp_valid = 1'b1;
        tick(); tick();
        smp_valid = 1'b0;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_cnt", smp_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for the team's combinational gate benches: it is the receiving end of the stimulus driver. It accepts sampled DUT triples {a, b, f} over a valid/ready handshake and compares each against the expected output of a selected 2-input function. It counts passes and failures, tracks coverage of all four input combinations, records the first mismatch and reports a final verdict. It sits between the DUT output sampler and the bench status logic, replacing manual `$monitor` inspection.

## Interface
- `NUM_SAMPLES`, default 4: samples accepted per run before completion; legal range 1..2^CNT_W-1.
- `CNT_W`, default 16: width of sample, pass and fail counters.
- `TIMEOUT`, default 64: idle cycles in RUN without an accepted sample before the run aborts; must be ≥1.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a new run.
- `gate_sel` input 2: expected function: 0=OR, 1=AND, 2=XOR, 3=NAND. Captured when `start` is accepted.
- `smp_valid` input 1: a sample is present.
- `smp_a`, `smp_b`, `smp_f` input 1 each: DUT inputs and the observed DUT output.
- `smp_ready` output 1: checker accepts a sample this cycle.
- `busy` output 1: run in progress.
- `done` output 1: run finished; results are stable.
- `pass` output 1: final verdict.
- `timed_out` output 1: the run ended by timeout.
- `pass_cnt`, `fail_cnt` output CNT_W: matching and mismatching samples.
- `smp_cnt` output CNT_W: samples accepted in this run.
- `cov_map` output 4: bit {a,b} set once that input combination has been seen.
- `first_fail_vec` output 3: {a,b,f} of the first mismatch.
- `first_fail_idx` output CNT_W: `smp_cnt` value at the first mismatch.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on acceptance of sample number NUM_SAMPLES, or on timeout.
  - DONE → RUN on `start`.
  - DONE has no automatic exit; results hold indefinitely.
- Accepting `start` in any state does all of the following:
  - clears all counters, `cov_map`, `first_fail_*` and `timed_out`;
  - latches `gate_sel`;
  - enters RUN.
- `start` in RUN therefore restarts the run. A sample presented in the same cycle as that `start` is discarded.
- A sample is accepted when `smp_valid` and `smp_ready` are both high. `smp_ready` is 1 exactly when the state is RUN and `start` is low.
- On each accepted sample:
  - `expected` = f(gate_sel_latched, a, b).
  - If `smp_f` == `expected`, `pass_cnt` increments. Otherwise `fail_cnt` increments.
  - On the first mismatch only, `first_fail_vec` and `first_fail_idx` are captured; the index is the pre-increment `smp_cnt`.
  - `smp_cnt` increments.
  - `cov_map[{a,b}]` is set.
- Counters saturate at all-ones. They never wrap.
- Timeout:
  - An idle counter increments on each RUN cycle with no acceptance and resets to 0 on any acceptance or on `start`.
  - When it reaches TIMEOUT: `timed_out` sets and the state goes to DONE.
- Verdict: `pass` = `done` and `fail_cnt`==0 and `timed_out`==0 and (`cov_map`==4'hF or NUM_SAMPLES<4).
- X or Z on `smp_f` counts as a mismatch.

## Timing
- Reset values:
  - state IDLE;
  - `smp_ready`=0, `busy`=0, `done`=0, `pass`=0, `timed_out`=0;
  - all counters 0, `cov_map`=0, `first_fail_vec`=0, `first_fail_idx`=0.
- `busy` = (state==RUN) and `done` = (state==DONE). Both are registered.
- Latency: a sample accepted in cycle N has its effect on the counters, `cov_map` and `first_fail_*` visible in cycle N+1.
- Completion: when the final sample is accepted in cycle N, `done`=1 and `busy`=0 in cycle N+1, and the final counts are visible in the same cycle.
- Timeout: with the last acceptance in cycle N and none after, `done` and `timed_out` rise in cycle N+TIMEOUT+1.
- A timeout and an acceptance never coincide, because an acceptance resets the idle counter.
- `start` accepted in cycle N: `busy`=1 and the cleared outputs are visible in cycle N+1; `smp_ready`=1 from cycle N+1.
- Reset asserted mid-run forces the reset values immediately (asynchronously). After `rst` deasserts, the block stays in IDLE until `start`.

## Test plan
- OR, four correct samples: `start` with `gate_sel`=0, then samples {0,0,0},{0,1,1},{1,0,1},{1,1,1} back-to-back. Required: `done` one cycle after the 4th sample, `pass_cnt`=4, `fail_cnt`=0, `cov_map`=4'hF, `pass`=1.
- One fault: as above but the third sample is {1,0,0}. Required: `fail_cnt`=1, `first_fail_vec`=3'b100, `first_fail_idx`=2, `pass`=0.
- Timeout: `TIMEOUT`=8, `start`, one sample, then `smp_valid` held low. Required: `done`=1 and `timed_out`=1 exactly 9 cycles after the acceptance, `smp_cnt`=1, `pass`=0.
- Incomplete coverage: NAND, four correct samples, all {1,1,0}. Required: `cov_map`=4'b1000, `fail_cnt`=0, `pass`=0.
- Restart and reset: `start` asserted while a sample is valid mid-run. Required: counters read 0 the next cycle and that sample is not counted. Then assert `rst` mid-run. Required: all outputs return to reset values asynchronously, before the next clock edge.
- Backpressure: `smp_valid` high in IDLE and in DONE. Required: `smp_ready`=0 and no counter changes.
